// File: rtl/mem_responder_if.sv
// Bundle of the core-facing memory ports (im/dm) plus the boot-loader byte
// stream and status lines of mem_responder.
// master = core/loader side, slave = mem_responder.
interface mem_responder_if;
  logic [31:0] im_addr_i;
  logic [31:0] im_dout_o;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_din_i;
  logic [31:0] dm_wen_i;
  logic [31:0] dm_dout_o;
  logic        ld_valid_i;
  logic [7:0]  ld_data_i;
  logic        ld_last_i;
  logic        ld_ready_o;
  logic        core_rst_n_o;
  logic        ld_overflow_o;

  modport master (
    output im_addr_i, dm_addr_i, dm_din_i, dm_wen_i,
    output ld_valid_i, ld_data_i, ld_last_i,
    input  im_dout_o, dm_dout_o, ld_ready_o, core_rst_n_o, ld_overflow_o
  );

  modport slave (
    input  im_addr_i, dm_addr_i, dm_din_i, dm_wen_i,
    input  ld_valid_i, ld_data_i, ld_last_i,
    output im_dout_o, dm_dout_o, ld_ready_o, core_rst_n_o, ld_overflow_o
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: word-addressed RAM with a registered instruction
// read port, a registered data read port with bit-masked writes, and a
// little-endian byte-stream boot loader that holds the core in reset.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter bit BOOT_LOAD   = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW:0] WADDR_FULL = (AW+1)'(DEPTH_WORDS);

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = BOOT_LOAD ? ST_LOAD : ST_RUN;

  logic [0:0]    state_reg;
  logic [1:0]    byte_cnt_reg;
  logic [23:0]   asm_reg;       // lower bytes of the word being assembled
  logic [AW:0]   waddr_reg;     // one extra bit so it can sit at DEPTH_WORDS
  logic          overflow_reg;
  logic          im_valid_reg;  // read data registered this cycle is real
  logic          dm_valid_reg;

  logic [AW-1:0] im_idx;
  logic [AW-1:0] dm_idx;
  logic          im_in_range;
  logic          dm_in_range;
  logic          in_load;
  logic          ld_accept;
  logic          ld_word_done;
  logic          ld_full;
  logic [31:0]   ld_word;

  logic [31:0]   wr_mask;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [31:0]   im_raw;
  logic [31:0]   dm_raw;
  logic          unused_addr_bits;

  // Byte offset bits carry no information for a word memory.
  assign unused_addr_bits = ^{bus.im_addr_i[1:0], bus.dm_addr_i[1:0]};

  assign im_idx      = bus.im_addr_i[AW+1:2];
  assign dm_idx      = bus.dm_addr_i[AW+1:2];
  assign im_in_range = (bus.im_addr_i[31:AW+2] == '0);
  assign dm_in_range = (bus.dm_addr_i[31:AW+2] == '0);

  assign in_load      = (state_reg == ST_LOAD);
  assign ld_accept    = bus.ld_valid_i & in_load;
  assign ld_word_done = ld_accept & ((byte_cnt_reg == 2'd3) | bus.ld_last_i);
  assign ld_full      = (waddr_reg == WADDR_FULL);

  // Merge the incoming byte into the partial word; upper bytes stay zero.
  always_comb begin
    ld_word = 32'h0;
    case (byte_cnt_reg)
      2'd0:    ld_word = {24'h0, bus.ld_data_i};
      2'd1:    ld_word = {16'h0, bus.ld_data_i, asm_reg[7:0]};
      2'd2:    ld_word = {8'h0, bus.ld_data_i, asm_reg[15:0]};
      default: ld_word = {bus.ld_data_i, asm_reg};
    endcase
  end

  // Single RAM write port shared by the loader (LOAD) and the dm port (RUN).
  always_comb begin
    wr_mask = '0;
    wr_idx  = '0;
    wr_data = '0;
    if (rst_n_i) begin
      if (in_load) begin
        if (ld_word_done && !ld_full) begin
          wr_mask = '1;
          wr_idx  = waddr_reg[AW-1:0];
          wr_data = ld_word;
        end
      end else if (dm_in_range) begin
        wr_mask = bus.dm_wen_i;
        wr_idx  = dm_idx;
        wr_data = bus.dm_din_i;
      end
    end
  end

  // One 1-bit-wide RAM column per data bit gives true per-bit write enables
  // without a read-modify-write; reads are read-first by construction.
  for (genvar gi = 0; gi < 32; gi++) begin : g_col
    logic col_mem [DEPTH_WORDS];
    logic im_bit_reg;
    logic dm_bit_reg;

    // Column write plus registered reads for both ports.
    always_ff @(posedge clk_i) begin
      if (wr_mask[gi]) begin
        col_mem[wr_idx] <= wr_data[gi];
      end
      im_bit_reg <= col_mem[im_idx];
      dm_bit_reg <= col_mem[dm_idx];
    end

    assign im_raw[gi] = im_bit_reg;
    assign dm_raw[gi] = dm_bit_reg;
  end

  // Control state: mode, loader byte assembly, write pointer, overflow flag.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg    <= ST_RESET;
      byte_cnt_reg <= 2'd0;
      asm_reg      <= 24'h0;
      waddr_reg    <= '0;
      overflow_reg <= 1'b0;
      im_valid_reg <= 1'b0;
      dm_valid_reg <= 1'b0;
    end else begin
      im_valid_reg <= !in_load && im_in_range;
      dm_valid_reg <= !in_load && dm_in_range;
      if (ld_accept) begin
        if (ld_word_done) begin
          byte_cnt_reg <= 2'd0;
          asm_reg      <= 24'h0;
          if (ld_full) begin
            overflow_reg <= 1'b1;
          end else begin
            waddr_reg <= waddr_reg + (AW+1)'(1);
          end
        end else begin
          byte_cnt_reg <= byte_cnt_reg + 2'd1;
          asm_reg      <= ld_word[23:0];
        end
        if (bus.ld_last_i) begin
          state_reg <= ST_RUN;
        end
      end
    end
  end

  assign bus.im_dout_o     = im_raw & {32{im_valid_reg}};
  assign bus.dm_dout_o     = dm_raw & {32{dm_valid_reg}};
  assign bus.ld_ready_o    = in_load;
  assign bus.core_rst_n_o  = !in_load;
  assign bus.ld_overflow_o = overflow_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed boot-load, masked write,
// read-first and range cases plus a randomized RUN phase, all compared
// against a word-array reference model.
module tb_mem_responder;

  typedef logic [7:0] byte_q_t [$];

  logic clk_i = 1'b0;
  logic rst_a_n;
  logic rst_b_n;

  always #5 clk_i = ~clk_i;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(.DEPTH_WORDS(1024), .BOOT_LOAD(1'b1)) u_dut_a (
    .clk_i   (clk_i),
    .rst_n_i (rst_a_n),
    .bus     (bus_a.slave)
  );

  mem_responder #(.DEPTH_WORDS(4), .BOOT_LOAD(1'b1)) u_dut_b (
    .clk_i   (clk_i),
    .rst_n_i (rst_b_n),
    .bus     (bus_b.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_a [1024];
  logic [31:0] ref_b [4];

  bit          pend = 1'b0;
  logic [31:0] pend_im;
  logic [31:0] pend_dm;
  string       pend_tag;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a byte address names word addr/4 and is valid below 4*depth.
  function automatic logic [31:0] model_rd_a(input logic [31:0] addr);
    if (addr >= 32'd4096) return 32'h0;
    return ref_a[addr / 4];
  endfunction

  function automatic void model_wr_a(input logic [31:0] addr, input logic [31:0] din,
                                     input logic [31:0] wen);
    if (addr < 32'd4096) begin
      for (int k = 0; k < 32; k++) begin
        if (wen[k]) ref_a[addr / 4][k] = din[k];
      end
    end
  endfunction

  // Reference loader: pack the stream little-endian into words; an unfinished
  // stream keeps only whole words; words past the depth are lost.
  function automatic bit model_load(input bit sel_b, input byte_q_t bytes, input bit complete);
    int n      = bytes.size();
    int depth  = sel_b ? 4 : 1024;
    int nwords = complete ? (n + 3) / 4 : n / 4;
    bit ovf    = 1'b0;
    for (int w = 0; w < nwords; w++) begin
      logic [31:0] val = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < n) val = val | ({24'h0, bytes[4 * w + k]} << (8 * k));
      end
      if (w < depth) begin
        if (sel_b) ref_b[w] = val;
        else       ref_a[w] = val;
      end else begin
        ovf = 1'b1;
      end
    end
    return ovf;
  endfunction

  task automatic drive_load(input bit sel_b, input byte_q_t bytes, input bit mark_last);
    for (int i = 0; i < bytes.size(); i++) begin
      bit is_last;
      @(negedge clk_i);
      is_last = mark_last && (i == bytes.size() - 1);
      if (is_last) begin
        check_val("ld_ready_before_last", 32'(sel_b ? bus_b.ld_ready_o : bus_a.ld_ready_o), 32'd1);
        check_val("core_rst_before_last", 32'(sel_b ? bus_b.core_rst_n_o : bus_a.core_rst_n_o), 32'd0);
      end
      if (sel_b) begin
        bus_b.ld_valid_i = 1'b1; bus_b.ld_data_i = bytes[i]; bus_b.ld_last_i = is_last;
      end else begin
        bus_a.ld_valid_i = 1'b1; bus_a.ld_data_i = bytes[i]; bus_a.ld_last_i = is_last;
      end
      $display("load %s byte %0d = %h last=%0d", sel_b ? "B" : "A", i, bytes[i], is_last);
    end
    @(negedge clk_i);
    bus_a.ld_valid_i = 1'b0; bus_a.ld_last_i = 1'b0;
    bus_b.ld_valid_i = 1'b0; bus_b.ld_last_i = 1'b0;
  endtask

  // One RUN cycle on DUT A; the previous cycle's reads are checked first.
  task automatic step_a(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] din,
                        input logic [31:0] wen, input string tag);
    @(negedge clk_i);
    if (pend) begin
      check_val({pend_tag, "/im"}, bus_a.im_dout_o, pend_im);
      check_val({pend_tag, "/dm"}, bus_a.dm_dout_o, pend_dm);
    end
    bus_a.im_addr_i = ia;
    bus_a.dm_addr_i = da;
    bus_a.dm_din_i  = din;
    bus_a.dm_wen_i  = wen;
    pend_im  = model_rd_a(ia);
    pend_dm  = model_rd_a(da);
    model_wr_a(da, din, wen);
    pend     = 1'b1;
    pend_tag = tag;
    $display("txn %s im_addr=%h dm_addr=%h din=%h wen=%h", tag, ia, da, din, wen);
  endtask

  task automatic flush_a();
    @(negedge clk_i);
    if (pend) begin
      check_val({pend_tag, "/im"}, bus_a.im_dout_o, pend_im);
      check_val({pend_tag, "/dm"}, bus_a.dm_dout_o, pend_dm);
    end
    pend = 1'b0;
    bus_a.dm_wen_i = 32'h0;
  endtask

  task automatic reset_a();
    @(negedge clk_i);
    rst_a_n = 1'b0;
    bus_a.ld_valid_i = 1'b0; bus_a.ld_last_i = 1'b0; bus_a.dm_wen_i = 32'h0;
    @(negedge clk_i);
    check_val("rst_im_dout", bus_a.im_dout_o, 32'h0);
    check_val("rst_dm_dout", bus_a.dm_dout_o, 32'h0);
    check_val("rst_overflow", 32'(bus_a.ld_overflow_o), 32'd0);
    check_val("rst_ld_ready", 32'(bus_a.ld_ready_o), 32'd1);
    check_val("rst_core_rst", 32'(bus_a.core_rst_n_o), 32'd0);
    rst_a_n = 1'b1;
    $display("reset A done");
  endtask

  task automatic rd_b(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk_i);
    bus_b.im_addr_i = addr;
    bus_b.dm_addr_i = addr;
    @(negedge clk_i);
    check_val({tag, "/im"}, bus_b.im_dout_o, exp);
    check_val({tag, "/dm"}, bus_b.dm_dout_o, exp);
    $display("read B addr=%h im=%h dm=%h", addr, bus_b.im_dout_o, bus_b.dm_dout_o);
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return {$urandom_range(1, 20'hFFFFF), 12'($urandom)};
    return {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t q;
    byte_q_t q2;
    bit      ovf_exp;
    logic [31:0] tmp;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.im_addr_i = 32'h0; bus_a.dm_addr_i = 32'h0; bus_a.dm_din_i = 32'h0; bus_a.dm_wen_i = 32'h0;
    bus_a.ld_valid_i = 1'b0; bus_a.ld_data_i = 8'h0; bus_a.ld_last_i = 1'b0;
    bus_b.im_addr_i = 32'h0; bus_b.dm_addr_i = 32'h0; bus_b.dm_din_i = 32'h0; bus_b.dm_wen_i = 32'h0;
    bus_b.ld_valid_i = 1'b0; bus_b.ld_data_i = 8'h0; bus_b.ld_last_i = 1'b0;

    // Test 1: eight-byte image
    reset_a();
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    ovf_exp = model_load(1'b0, q, 1'b1);
    drive_load(1'b0, q, 1'b1);
    check_val("t1_core_rst", 32'(bus_a.core_rst_n_o), 32'd1);
    check_val("t1_ld_ready", 32'(bus_a.ld_ready_o), 32'd0);
    check_val("t1_overflow", 32'(bus_a.ld_overflow_o), 32'(ovf_exp));
    step_a(32'h0, 32'h4, 32'h0, 32'h0, "t1_rd");
    flush_a();

    // Test 2: five-byte image, last word zero-padded; lone last has no effect
    reset_a();
    @(negedge clk_i);
    bus_a.ld_last_i = 1'b1;
    @(negedge clk_i);
    bus_a.ld_last_i = 1'b0;
    check_val("t2_last_no_valid", 32'(bus_a.ld_ready_o), 32'd1);
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    ovf_exp = model_load(1'b0, q, 1'b1);
    drive_load(1'b0, q, 1'b1);
    check_val("t2_overflow", 32'(bus_a.ld_overflow_o), 32'(ovf_exp));
    step_a(32'h4, 32'h0, 32'h0, 32'h0, "t2_rd");

    // Known contents for words 0..15 (word 4 zero), plus the top word
    for (int w = 0; w < 16; w++) begin
      step_a(32'h0, 32'(w * 4), (w == 4) ? 32'h0 : $urandom, 32'hFFFF_FFFF, "init");
    end
    step_a(32'h0, 32'hFFC, $urandom, 32'hFFFF_FFFF, "init_top");

    // Test 3: masked write, read-first then new data
    step_a(32'h0, 32'h10, 32'hFFFF_FFFF, 32'h0000_FF00, "t3_wr");
    step_a(32'h0, 32'h10, 32'h0, 32'h0, "t3_rd");

    // Test 4: im read-first, out-of-range accesses, top in-range word
    step_a(32'h4, 32'h4, $urandom, $urandom | 32'h1, "t4_wr");
    step_a(32'h4, 32'h0, 32'h0, 32'h0, "t4_rd");
    step_a(32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, "t4_oor");
    step_a(32'h0, 32'h8000_0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t4_oor_wr");
    step_a(32'h1000, 32'h10, 32'h0, 32'h0, "t4_chk");
    step_a(32'hFFF, 32'hFFE, 32'h0, 32'h0, "t4_top");

    // Random RUN traffic; loader inputs wiggle but must be ignored
    for (int i = 0; i < 300; i++) begin
      logic [31:0] wen;
      wen = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      bus_a.ld_valid_i = 1'($urandom_range(0, 1));
      bus_a.ld_data_i  = 8'($urandom);
      step_a(rnd_addr(), rnd_addr(), $urandom, wen, "rnd");
    end
    flush_a();
    bus_a.ld_valid_i = 1'b0;
    check_val("run_ld_ready", 32'(bus_a.ld_ready_o), 32'd0);
    check_val("run_core_rst", 32'(bus_a.core_rst_n_o), 32'd1);

    // Test 6: abort mid-load, then reload
    reset_a();
    q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    ovf_exp = model_load(1'b0, q, 1'b0);
    drive_load(1'b0, q, 1'b0);
    @(negedge clk_i);
    rst_a_n = 1'b0;
    @(negedge clk_i);
    check_val("t6_ld_ready", 32'(bus_a.ld_ready_o), 32'd1);
    check_val("t6_core_rst", 32'(bus_a.core_rst_n_o), 32'd0);
    rst_a_n = 1'b1;
    tmp = ~ref_a[5];
    bus_a.im_addr_i = 32'h14; bus_a.dm_addr_i = 32'h14; bus_a.dm_din_i = tmp; bus_a.dm_wen_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check_val("t6_load_im_zero", bus_a.im_dout_o, 32'h0);
    check_val("t6_load_dm_zero", bus_a.dm_dout_o, 32'h0);
    bus_a.dm_wen_i = 32'h0;
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    ovf_exp = model_load(1'b0, q, 1'b1);
    drive_load(1'b0, q, 1'b1);
    check_val("t6_overflow", 32'(bus_a.ld_overflow_o), 32'(ovf_exp));
    step_a(32'h0, 32'h4, 32'h0, 32'h0, "t6_rd01");
    step_a(32'h14, 32'h14, 32'h0, 32'h0, "t6_rd5");
    flush_a();

    // Test 5: DEPTH_WORDS=4 overflow
    @(negedge clk_i);
    check_val("t5_rst_ld_ready", 32'(bus_b.ld_ready_o), 32'd1);
    check_val("t5_rst_core_rst", 32'(bus_b.core_rst_n_o), 32'd0);
    check_val("t5_rst_overflow", 32'(bus_b.ld_overflow_o), 32'd0);
    rst_b_n = 1'b1;
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    ovf_exp = model_load(1'b1, q, 1'b1);
    q2 = q[0:15];
    drive_load(1'b1, q2, 1'b0);
    check_val("t5_ovf_after_4w", 32'(bus_b.ld_overflow_o), 32'd0);
    check_val("t5_core_mid", 32'(bus_b.core_rst_n_o), 32'd0);
    q2 = q[16:19];
    drive_load(1'b1, q2, 1'b1);
    check_val("t5_ovf_after_5w", 32'(bus_b.ld_overflow_o), 32'(ovf_exp));
    check_val("t5_core_rst", 32'(bus_b.core_rst_n_o), 32'd1);
    check_val("t5_ld_ready", 32'(bus_b.ld_ready_o), 32'd0);
    for (int w = 0; w < 4; w++) rd_b(32'(w * 4), ref_b[w], "t5_word");
    rd_b(32'h10, 32'h0, "t5_oor");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
